// File: rtl/fc_sequencer.sv
// fc_sequencer: time-multiplexed controller for one fully connected layer.
// A single signed MAC computes every output neuron in turn. For each channel c
// it walks the flattened input (index k) and the weight row c*FLAT+k, adds the
// bias for c, and streams the saturated result out over a valid/ready handshake.
//
// Ports
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   start                   begin one layer pass (sampled only while idle)
//   busy, done              pass in progress / one-cycle completion pulse
//   in_addr / in_data       flat input memory, 1-cycle synchronous read
//   w_addr  / w_data        weight memory (c*FLAT+k), 1-cycle synchronous read
//   b_addr  / b_data        bias memory (c), 1-cycle synchronous read
//   out_valid/out_ready     result handshake
//   out_data, out_ch        saturated result and its channel index
module fc_sequencer #(
  parameter int INPUT_SIZE      = 5,
  parameter int INPUT_CHANNELS  = 3,
  parameter int OUTPUT_CHANNELS = 3,
  parameter int PX_SIZE         = 8,
  parameter int RELU            = 0,
  localparam int FLAT     = INPUT_SIZE * INPUT_SIZE * INPUT_CHANNELS,
  localparam int ACC_SIZE = 2 * PX_SIZE + $clog2(FLAT) + 1,
  // Address widths are floored at 1 bit so degenerate sizes still elaborate.
  localparam int AW = (FLAT > 1) ? $clog2(FLAT) : 1,
  localparam int WW = (OUTPUT_CHANNELS * FLAT > 1) ? $clog2(OUTPUT_CHANNELS * FLAT) : 1,
  localparam int CW = (OUTPUT_CHANNELS > 1) ? $clog2(OUTPUT_CHANNELS) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [AW-1:0]      in_addr,
  input  logic [PX_SIZE-1:0] in_data,
  output logic [WW-1:0]      w_addr,
  input  logic [PX_SIZE-1:0] w_data,
  output logic [CW-1:0]      b_addr,
  input  logic [PX_SIZE-1:0] b_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PX_SIZE-1:0] out_data,
  output logic [CW-1:0]      out_ch
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MAC,
    S_DRAIN,
    S_BIAS,
    S_EMIT,
    S_DONE
  } state_t;

  localparam logic signed [ACC_SIZE-1:0] SAT_MAX = ACC_SIZE'((2 ** (PX_SIZE - 1)) - 1);
  localparam logic signed [ACC_SIZE-1:0] SAT_MIN = ~SAT_MAX;

  state_t                       r_state;
  state_t                       w_next;
  logic [CW-1:0]                r_c;
  logic [AW-1:0]                r_k;
  logic signed [ACC_SIZE-1:0]   r_acc;
  logic                         r_mac_v;   // memory data on the bus belongs to a MAC address

  logic                         w_last_k;
  logic                         w_last_c;
  logic signed [2*PX_SIZE-1:0]  w_prod;
  logic signed [ACC_SIZE-1:0]   w_prod_ext;
  logic signed [ACC_SIZE-1:0]   w_bias_ext;
  logic [PX_SIZE-1:0]           w_result;

  assign w_last_k   = (r_k == AW'(FLAT - 1));
  assign w_last_c   = (r_c == CW'(OUTPUT_CHANNELS - 1));
  assign w_prod     = $signed(in_data) * $signed(w_data);
  assign w_prod_ext = ACC_SIZE'(w_prod);
  assign w_bias_ext = ACC_SIZE'($signed(b_data));

  // Addresses come straight from the counters, so data returned one cycle
  // later always lines up with the counter values of the previous cycle.
  assign in_addr = r_k;
  assign w_addr  = WW'(r_c) * WW'(FLAT) + WW'(r_k);
  assign b_addr  = r_c;
  assign out_ch  = r_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // NOTE: every signal driven here gets a default before the case, so no
  // path can leave one unassigned and infer a latch.
  always_comb begin
    w_next    = r_state;
    busy      = 1'b1;
    done      = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) w_next = S_MAC;
      end
      S_MAC:   if (w_last_k) w_next = S_DRAIN;
      S_DRAIN: w_next = S_BIAS;
      S_BIAS:  w_next = S_EMIT;
      S_EMIT: begin
        out_valid = 1'b1;
        if (out_ready) w_next = w_last_c ? S_DONE : S_MAC;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // NOTE: all state updates use non-blocking assignments so every register
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_c     <= '0;
      r_k     <= '0;
      r_acc   <= '0;
      r_mac_v <= 1'b0;
    end else begin
      // Accumulates during MAC and for the trailing product in DRAIN.
      if (r_mac_v) r_acc <= r_acc + w_prod_ext;
      case (r_state)
        S_IDLE: begin
          r_c     <= '0;
          r_k     <= '0;
          r_acc   <= '0;
          r_mac_v <= 1'b0;
        end
        S_MAC: begin
          r_mac_v <= 1'b1;
          // k parks at FLAT-1 until the channel advances.
          if (!w_last_k) r_k <= r_k + 1'b1;
        end
        S_DRAIN: r_mac_v <= 1'b0;
        S_BIAS:  r_acc <= r_acc + w_bias_ext;
        S_EMIT: begin
          if (out_ready && !w_last_c) begin
            r_c   <= r_c + 1'b1;
            r_k   <= '0;
            r_acc <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Saturate to the signed pixel range, then optionally rectify.
  always_comb begin
    w_result = r_acc[PX_SIZE-1:0];
    if (r_acc > SAT_MAX) begin
      w_result = {1'b0, {(PX_SIZE - 1){1'b1}}};
    end else if (r_acc < SAT_MIN) begin
      w_result = {1'b1, {(PX_SIZE - 1){1'b0}}};
    end
    if ((RELU != 0) && w_result[PX_SIZE-1]) w_result = '0;
  end

  assign out_data = out_valid ? w_result : '0;

endmodule

// File: tb/tb_fc_sequencer.sv
// Self-checking bench for fc_sequencer. Two instances share stimulus: one with
// RELU=0 and one with RELU=1. Memories are modelled with 1-cycle read latency.
// Expected results come from a direct dot-product model over the memory arrays.
// Clock labels: label n is the n-th rising edge after the start-accept edge;
// signals are observed on the falling edge just before that rising edge.
module tb_fc_sequencer;

  localparam int FLAT    = 75;
  localparam int OC      = 3;
  localparam int CH_CLKS = FLAT + 3;
  localparam int BUDGET  = 3000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       out_ready;

  logic       busy, done, out_valid;
  logic [6:0] in_addr;
  logic [7:0] w_addr;
  logic [1:0] b_addr, out_ch;
  logic [7:0] in_data, w_data, b_data, out_data;

  logic       busy_r, done_r, out_valid_r;
  logic [6:0] in_addr_r;
  logic [7:0] w_addr_r;
  logic [1:0] b_addr_r, out_ch_r;
  logic [7:0] in_data_r, w_data_r, b_data_r, out_data_r;

  logic signed [7:0] mem_in [FLAT];
  logic signed [7:0] mem_w  [OC*FLAT];
  logic signed [7:0] mem_b  [OC];

  int errors = 0;
  int checks = 0;

  // Observations collected by run_pass.
  int                hs_clk    [OC];
  int                hs_ch     [OC];
  logic signed [7:0] hs_data   [OC];
  logic signed [7:0] hs_data_r [OC];
  int                n_hs;
  int                done_clk;
  int                stall_bad;
  int                sync_bad;

  fc_sequencer #(.RELU(0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .in_addr(in_addr), .in_data(in_data), .w_addr(w_addr), .w_data(w_data),
    .b_addr(b_addr), .b_data(b_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ch(out_ch)
  );

  fc_sequencer #(.RELU(1)) dut_relu (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy_r), .done(done_r),
    .in_addr(in_addr_r), .in_data(in_data_r), .w_addr(w_addr_r), .w_data(w_data_r),
    .b_addr(b_addr_r), .b_data(b_data_r), .out_valid(out_valid_r), .out_ready(out_ready),
    .out_data(out_data_r), .out_ch(out_ch_r)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    in_data   <= mem_in[in_addr];
    w_data    <= mem_w[w_addr];
    b_data    <= mem_b[b_addr];
    in_data_r <= mem_in[in_addr_r];
    w_data_r  <= mem_w[w_addr_r];
    b_data_r  <= mem_b[b_addr_r];
  end

  // Reference: bias plus dot product, clipped to 8-bit signed, optional ReLU.
  function automatic logic signed [7:0] ref_out(input int c, input bit relu);
    longint s = mem_b[c];
    for (int k = 0; k < FLAT; k++) s += longint'(mem_in[k]) * longint'(mem_w[c*FLAT+k]);
    if (s > 127) s = 127;
    else if (s < -128) s = -128;
    if (relu && s < 0) s = 0;
    return 8'(s);
  endfunction

  // Handshake clock of channel n, delayed by a stall on channel sc and later ones.
  function automatic int exp_clk(input int n, input int sc, input int sn);
    return CH_CLKS * (n + 1) + ((sc >= 0 && n >= sc) ? sn : 0);
  endfunction

  task automatic fill_random();
    for (int k = 0; k < FLAT; k++) mem_in[k] = 8'($urandom);
    for (int i = 0; i < OC*FLAT; i++) mem_w[i] = 8'($urandom);
    for (int c = 0; c < OC; c++) mem_b[c] = 8'($urandom);
  endtask

  // Runs one pass. stall_ch holds out_ready low for stall_n EMIT cycles on that
  // channel; restart_at re-pulses start at that label; hold_start keeps start high.
  task automatic run_pass(input int stall_ch, input int stall_n, input int restart_at,
                          input bit hold_start);
    int stall_cnt = 0;
    logic [7:0] s_d, s_dr, s_wa;
    logic [6:0] s_ia;
    logic [1:0] s_ch, s_ba;
    n_hs = 0; done_clk = -1; stall_bad = 0; sync_bad = 0;
    @(negedge clk);
    start = 1'b1;
    out_ready = 1'($urandom);
    for (int cyc = 1; cyc <= BUDGET && done_clk < 0; cyc++) begin
      @(negedge clk);
      start = hold_start || (cyc == restart_at);
      if (!busy || done !== done_r || out_valid !== out_valid_r) sync_bad++;
      if (done) begin
        done_clk = cyc;
      end else if (out_valid) begin
        if (int'(out_ch) == stall_ch && stall_cnt < stall_n) begin
          if (stall_cnt == 0) begin
            s_d = out_data; s_dr = out_data_r; s_ch = out_ch;
            s_ia = in_addr; s_wa = w_addr; s_ba = b_addr;
          end else if (out_data !== s_d || out_data_r !== s_dr || out_ch !== s_ch ||
                       in_addr !== s_ia || w_addr !== s_wa || b_addr !== s_ba) begin
            stall_bad++;
          end
          stall_cnt++;
          out_ready = 1'b0;
        end else begin
          if (n_hs < OC) begin
            hs_clk[n_hs] = cyc; hs_ch[n_hs] = int'(out_ch);
            hs_data[n_hs] = out_data; hs_data_r[n_hs] = out_data_r;
          end
          n_hs++;
          out_ready = 1'b1;
        end
      end else begin
        out_ready = 1'($urandom);
      end
    end
    start = hold_start;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; out_ready = 1'b0;
    #1;
    checks++;
    if ({busy, done, out_valid, busy_r, done_r, out_valid_r} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b required 000000", {busy, done, out_valid, busy_r, done_r, out_valid_r});
    end
    checks++;
    if (out_data !== 8'd0 || out_ch !== 2'd0 || out_data_r !== 8'd0) begin
      errors++;
      $display("FAIL reset_out: got data=%0d ch=%0d relu_data=%0d required 0", out_data, out_ch, out_data_r);
    end
    checks++;
    if (in_addr !== 7'd0 || w_addr !== 8'd0 || b_addr !== 2'd0) begin
      errors++;
      $display("FAIL reset_addr: got in=%0d w=%0d b=%0d required 0", in_addr, w_addr, b_addr);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_busy: got %b required 0", busy);
    end
  endtask

  task automatic test_basic();
    for (int k = 0; k < FLAT; k++) mem_in[k] = 8'sd1;
    for (int i = 0; i < OC*FLAT; i++) mem_w[i] = 8'sd1;
    for (int c = 0; c < OC; c++) mem_b[c] = 8'sd0;
    run_pass(-1, 0, 0, 1'b0);
    checks++;
    if (n_hs !== OC || sync_bad !== 0) begin
      errors++;
      $display("FAIL basic_count: got handshakes=%0d sync_errs=%0d required %0d/0", n_hs, sync_bad, OC);
    end
    for (int c = 0; c < OC; c++) begin
      checks++;
      if (hs_data[c] !== 8'sd75 || hs_data_r[c] !== 8'sd75 || hs_ch[c] !== c) begin
        errors++;
        $display("FAIL basic_data ch%0d: got %0d/%0d ch=%0d required 75/75 ch=%0d",
                 c, hs_data[c], hs_data_r[c], hs_ch[c], c);
      end
      checks++;
      if (hs_clk[c] !== exp_clk(c, -1, 0)) begin
        errors++;
        $display("FAIL basic_timing ch%0d: got clock %0d required %0d", c, hs_clk[c], exp_clk(c, -1, 0));
      end
    end
    checks++;
    if (done_clk !== 235) begin
      errors++;
      $display("FAIL basic_done: got clock %0d required 235", done_clk);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse: got done=%b busy=%b required 0/0", done, busy);
    end
  endtask

  task automatic test_saturation();
    logic signed [7:0] e0 [2];
    logic signed [7:0] e1 [2];
    e0[0] = 8'sd127; e1[0] = 8'sd127;
    e0[1] = -8'sd128; e1[1] = 8'sd0;
    for (int pass = 0; pass < 2; pass++) begin
      for (int k = 0; k < FLAT; k++) mem_in[k] = 8'sd127;
      for (int i = 0; i < OC*FLAT; i++) mem_w[i] = (pass == 0) ? 8'sd127 : -8'sd128;
      for (int c = 0; c < OC; c++) mem_b[c] = 8'sd0;
      run_pass(-1, 0, 0, 1'b0);
      for (int c = 0; c < OC; c++) begin
        checks++;
        if (hs_data[c] !== e0[pass] || hs_data_r[c] !== e1[pass]) begin
          errors++;
          $display("FAIL sat%0d ch%0d: got %0d/%0d required %0d/%0d",
                   pass, c, hs_data[c], hs_data_r[c], e0[pass], e1[pass]);
        end
      end
    end
  endtask

  task automatic test_bias_scaled();
    logic signed [7:0] e [OC];
    e[0] = 8'sd70; e[1] = 8'sd127; e[2] = 8'sd127;
    for (int k = 0; k < FLAT; k++) mem_in[k] = 8'sd1;
    for (int c = 0; c < OC; c++) begin
      for (int k = 0; k < FLAT; k++) mem_w[c*FLAT+k] = 8'(c + 1);
      mem_b[c] = -8'sd5;
    end
    run_pass(-1, 0, 0, 1'b0);
    for (int c = 0; c < OC; c++) begin
      checks++;
      if (hs_data[c] !== e[c] || hs_data_r[c] !== e[c] || hs_ch[c] !== c) begin
        errors++;
        $display("FAIL bias ch%0d: got %0d/%0d ch=%0d required %0d ch=%0d",
                 c, hs_data[c], hs_data_r[c], hs_ch[c], e[c], c);
      end
    end
  endtask

  task automatic test_stall();
    fill_random();
    run_pass(1, 10, 0, 1'b0);
    checks++;
    if (stall_bad !== 0) begin
      errors++;
      $display("FAIL stall_stable: got %0d changes required 0", stall_bad);
    end
    for (int c = 0; c < OC; c++) begin
      checks++;
      if (hs_data[c] !== ref_out(c, 0) || hs_data_r[c] !== ref_out(c, 1) ||
          hs_clk[c] !== exp_clk(c, 1, 10)) begin
        errors++;
        $display("FAIL stall ch%0d: got %0d/%0d at %0d required %0d/%0d at %0d", c,
                 hs_data[c], hs_data_r[c], hs_clk[c], ref_out(c, 0), ref_out(c, 1), exp_clk(c, 1, 10));
      end
    end
    checks++;
    if (done_clk !== 245) begin
      errors++;
      $display("FAIL stall_done: got clock %0d required 245", done_clk);
    end
  endtask

  task automatic test_restart();
    fill_random();
    run_pass(-1, 0, 40, 1'b0);
    for (int c = 0; c < OC; c++) begin
      checks++;
      if (hs_data[c] !== ref_out(c, 0) || hs_ch[c] !== c || hs_clk[c] !== exp_clk(c, -1, 0)) begin
        errors++;
        $display("FAIL restart ch%0d: got %0d ch=%0d at %0d required %0d ch=%0d at %0d", c,
                 hs_data[c], hs_ch[c], hs_clk[c], ref_out(c, 0), c, exp_clk(c, -1, 0));
      end
    end
    checks++;
    if (done_clk !== 235 || n_hs !== OC) begin
      errors++;
      $display("FAIL restart_done: got clock %0d handshakes %0d required 235/%0d", done_clk, n_hs, OC);
    end
  endtask

  task automatic test_start_held();
    fill_random();
    run_pass(-1, 0, 0, 1'b1);
    checks++;
    if (done_clk !== 235 || hs_data[OC-1] !== ref_out(OC-1, 0)) begin
      errors++;
      $display("FAIL held_pass: got done %0d data %0d required 235/%0d", done_clk, hs_data[OC-1], ref_out(OC-1, 0));
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL held_idle: got busy=%b required 0", busy);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL held_accept: got busy=%b required 1", busy);
    end
    start = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_abort();
    int spurious = 0;
    fill_random();
    @(negedge clk);
    start = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    checks++;
    if (busy !== 1'b1 || out_ch !== 2'd1) begin
      errors++;
      $display("FAIL abort_pre: got busy=%b ch=%0d required 1/1", busy, out_ch);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, out_valid, busy_r, out_valid_r} !== 5'b0 || out_data !== 8'd0 ||
        out_ch !== 2'd0 || w_addr !== 8'd0 || in_addr !== 7'd0) begin
      errors++;
      $display("FAIL abort_async: got busy=%b valid=%b data=%0d ch=%0d w=%0d required zeros",
               busy, out_valid, out_data, out_ch, w_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      out_ready = 1'($urandom);
      if (done || out_valid || busy || done_r || out_valid_r) spurious++;
    end
    checks++;
    if (spurious !== 0) begin
      errors++;
      $display("FAIL abort_quiet: got %0d active cycles required 0", spurious);
    end
    run_pass(-1, 0, 0, 1'b0);
    for (int c = 0; c < OC; c++) begin
      checks++;
      if (hs_data[c] !== ref_out(c, 0) || hs_data_r[c] !== ref_out(c, 1) || hs_ch[c] !== c) begin
        errors++;
        $display("FAIL abort_rerun ch%0d: got %0d/%0d ch=%0d required %0d/%0d ch=%0d", c,
                 hs_data[c], hs_data_r[c], hs_ch[c], ref_out(c, 0), ref_out(c, 1), c);
      end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      int sc = $urandom_range(0, OC - 1);
      int sn = $urandom_range(0, 6);
      fill_random();
      run_pass(sc, sn, 0, 1'b0);
      checks++;
      if (done_clk !== exp_clk(OC - 1, sc, sn) + 1 || n_hs !== OC || sync_bad !== 0) begin
        errors++;
        $display("FAIL rand%0d_done: got %0d hs=%0d sync=%0d required %0d hs=%0d", it,
                 done_clk, n_hs, sync_bad, exp_clk(OC - 1, sc, sn) + 1, OC);
      end
      for (int c = 0; c < OC; c++) begin
        checks++;
        if (hs_data[c] !== ref_out(c, 0) || hs_data_r[c] !== ref_out(c, 1) ||
            hs_clk[c] !== exp_clk(c, sc, sn)) begin
          errors++;
          $display("FAIL rand%0d ch%0d: got %0d/%0d at %0d required %0d/%0d at %0d", it, c,
                   hs_data[c], hs_data_r[c], hs_clk[c], ref_out(c, 0), ref_out(c, 1), exp_clk(c, sc, sn));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_bias_scaled();
    test_stall();
    test_restart();
    test_start_held();
    test_abort();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
